// File: rtl/mem_ring_client.sv
// mem_ring_client: streaming 32-bit FIFO front end that keeps its words in an
// external RAM organised as a ring buffer. The RAM is reached through a
// single-outstanding req/busy handshake. One holding register sits on the push
// side and one on the pop side. The pop side prefetches from RAM whenever its
// register is empty.
module mem_ring_client #(
  parameter int unsigned       ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       DEPTH       = 1 << 20,
  parameter int unsigned       ACK_TIMEOUT = 15
) (
  input  logic              sys_clk,
  input  logic              reset,
  // push side
  input  logic [31:0]       wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  // pop side
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  // control / status
  input  logic              flush,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              timeout_err,
  // memory request interface
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_req,
  output logic              mem_read_req,
  input  logic              mem_busy
);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam int unsigned       TMO_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACK  = 3'd1,
    WR_DONE = 3'd2,
    RD_ACK  = 3'd3,
    RD_DONE = 3'd4
  } state_e;

  state_e            state_q,       state_d;
  logic [ADDR_W-1:0] wptr_q,        wptr_d;
  logic [ADDR_W-1:0] rptr_q,        rptr_d;
  logic [ADDR_W:0]   count_q,       count_d;
  logic              in_full_q,     in_full_d;
  logic [31:0]       in_data_q,     in_data_d;
  logic              out_full_q,    out_full_d;
  logic [31:0]       out_data_q,    out_data_d;
  logic              flush_pend_q,  flush_pend_d;
  logic              timeout_err_q, timeout_err_d;
  logic [TMO_W-1:0]  tmo_cnt_q,     tmo_cnt_d;
  logic              last_wr_q,     last_wr_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [31:0]       mem_wdata_q,   mem_wdata_d;
  logic              write_req_q,   write_req_d;
  logic              read_req_q,    read_req_d;

  logic push;
  logic pop;
  logic wr_pend;
  logic rd_pend;

  // Ring pointer increment with wrap at the end of the ring.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + ADDR_W'(1);
  endfunction

  assign wr_ready      = !in_full_q && !flush_pend_q;
  assign rd_valid      = out_full_q;
  assign rd_data       = out_data_q;
  assign count         = count_q;
  assign full          = (count_q == DEPTH_C);
  assign empty         = (count_q == '0);
  assign timeout_err   = timeout_err_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data_o    = mem_wdata_q;
  assign mem_write_req = write_req_q;
  assign mem_read_req  = read_req_q;

  assign push    = wr_valid && wr_ready;
  assign pop     = rd_valid && rd_ready;
  assign wr_pend = in_full_q && !full;
  assign rd_pend = !out_full_q && !empty;

  // Next-state, holding-register and memory-request logic.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d       = state_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    in_full_d     = in_full_q;
    in_data_d     = in_data_q;
    out_full_d    = out_full_q;
    out_data_d    = out_data_q;
    flush_pend_d  = flush_pend_q || flush;
    timeout_err_d = timeout_err_q;
    tmo_cnt_d     = tmo_cnt_q;
    last_wr_d     = last_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    write_req_d   = 1'b0;
    read_req_d    = 1'b0;

    if (push) begin
      in_full_d = 1'b1;
      in_data_d = wr_data;
    end
    if (pop) begin
      out_full_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (flush_pend_q) begin
          // Flush is only applied between memory operations.
          wptr_d        = '0;
          rptr_d        = '0;
          count_d       = '0;
          in_full_d     = 1'b0;
          in_data_d     = '0;
          out_full_d    = 1'b0;
          out_data_d    = '0;
          timeout_err_d = 1'b0;
          flush_pend_d  = flush;
        end else if (!mem_busy && wr_pend && (!rd_pend || !last_wr_q)) begin
          // Write wins when it is the only request or it is its turn.
          state_d     = WR_ACK;
          write_req_d = 1'b1;
          mem_addr_d  = BASE_ADDR + wptr_q;
          mem_wdata_d = in_data_q;
          last_wr_d   = 1'b1;
        end else if (!mem_busy && rd_pend) begin
          state_d    = RD_ACK;
          read_req_d = 1'b1;
          mem_addr_d = BASE_ADDR + rptr_q;
          last_wr_d  = 1'b0;
        end
      end

      WR_ACK, RD_ACK: begin
        if (mem_busy) begin
          state_d = (state_q == WR_ACK) ? WR_DONE : RD_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Memory never acknowledged: give up; the word stays queued for retry.
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      WR_DONE: begin
        if (!mem_busy) begin
          state_d = IDLE;
          wptr_d  = ptr_inc(wptr_q);
          count_d = count_q + (ADDR_W + 1)'(1);
          if (!push) begin
            in_full_d = 1'b0;
          end
        end
      end

      RD_DONE: begin
        if (!mem_busy) begin
          // Read data is valid in the first cycle busy is low again.
          state_d    = IDLE;
          out_data_d = mem_data_i;
          out_full_d = 1'b1;
          rptr_d     = ptr_inc(rptr_q);
          count_d    = count_q - (ADDR_W + 1)'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      in_full_q     <= 1'b0;
      in_data_q     <= '0;
      out_full_q    <= 1'b0;
      out_data_q    <= '0;
      flush_pend_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
      last_wr_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      write_req_q   <= 1'b0;
      read_req_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      in_full_q     <= in_full_d;
      in_data_q     <= in_data_d;
      out_full_q    <= out_full_d;
      out_data_q    <= out_data_d;
      flush_pend_q  <= flush_pend_d;
      timeout_err_q <= timeout_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
      last_wr_q     <= last_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      write_req_q   <= write_req_d;
      read_req_q    <= read_req_d;
    end
  end

endmodule

// File: tb/tb_mem_ring_client.sv
// Bench for mem_ring_client with a 4-word ring and a req/busy memory model.
// Pushed words are queued as expected pop data and expected write data; the
// pop monitor and the memory model compare against those queues and against
// the expected ring addresses.
module tb_mem_ring_client;

  localparam int ADDR_W   = 20;
  localparam int DEPTH    = 4;
  localparam int BUSY_LEN = 3;

  logic              sys_clk = 1'b0;
  logic              reset   = 1'b0;
  logic [31:0]       wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              flush;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              timeout_err;
  logic [31:0]       mem_data_o;
  logic [31:0]       mem_data_i = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write_req;
  logic              mem_read_req;
  logic              mem_busy   = 1'b0;

  always #5 sys_clk = ~sys_clk;

  mem_ring_client #(
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  ('0),
    .DEPTH      (DEPTH),
    .ACK_TIMEOUT(15)
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .flush        (flush),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .timeout_err  (timeout_err),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_addr     (mem_addr),
    .mem_write_req(mem_write_req),
    .mem_read_req (mem_read_req),
    .mem_busy     (mem_busy)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;
  logic [31:0] exp_rd[$];
  logic [31:0] exp_wr[$];
  bit          never_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: busy for BUSY_LEN cycles starting the cycle after a request.
  int                m_cnt      = 0;
  bit                m_is_wr    = 1'b0;
  logic [ADDR_W-1:0] m_addr     = '0;
  logic [31:0]       m_data     = '0;
  int                exp_wptr   = 0;
  int                exp_rptr   = 0;
  bit                flush_seen = 1'b0;
  logic [31:0]       mem_model [16];

  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      mem_busy   <= 1'b0;
      mem_data_i <= '0;
      m_cnt      <= 0;
      m_is_wr    <= 1'b0;
      m_addr     <= '0;
      m_data     <= '0;
      exp_wptr   <= 0;
      exp_rptr   <= 0;
      flush_seen <= 1'b0;
    end else begin
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          mem_busy <= 1'b0;
          if (m_is_wr) begin
            mem_model[m_addr[3:0]] <= m_data;
            check("wr_addr", 64'(m_addr), 64'(exp_wptr));
            if (exp_wr.size() == 0) check("wr_unexpected", 64'(1), 64'(0));
            else check("wr_data", 64'(m_data), 64'(exp_wr.pop_front()));
            exp_wptr <= (exp_wptr + 1) % DEPTH;
          end else begin
            mem_data_i <= mem_model[m_addr[3:0]];
            check("rd_addr", 64'(m_addr), 64'(exp_rptr));
            exp_rptr <= (exp_rptr + 1) % DEPTH;
          end
        end
      end else begin
        if (flush_seen) begin
          exp_wptr   <= 0;
          exp_rptr   <= 0;
          flush_seen <= 1'b0;
        end
        if (!never_busy && (mem_write_req || mem_read_req)) begin
          mem_busy <= 1'b1;
          m_cnt    <= BUSY_LEN;
          m_is_wr  <= mem_write_req;
          m_addr   <= mem_addr;
          m_data   <= mem_data_o;
        end
      end
      if (flush) flush_seen <= 1'b1;
    end
  end

  // Pop monitor: every transfer must match the oldest expected word.
  always @(negedge sys_clk) begin
    if (!reset && rd_valid && rd_ready) begin
      if (exp_rd.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
      else check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
      n_pop <= n_pop + 1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] d);
    bit ok;
    ok       = 1'b0;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge sys_clk);
      ok = wr_ready;
      @(posedge sys_clk);
      #1;
    end
    wr_valid = 1'b0;
    if (ok) begin
      exp_rd.push_back(d);
      exp_wr.push_back(d);
    end else begin
      check("push_accept", 64'(0), 64'(1));
    end
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    rd_ready = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    rd_ready = 1'b1;
    while (exp_rd.size() != 0 && i < 5000) begin
      @(posedge sys_clk);
      #1;
      i++;
    end
    rd_ready = 1'b0;
    check("drain_done", 64'(exp_rd.size()), 64'(0));
  endtask

  // Returns at the falling edge of the cycle in which the request is high.
  task automatic wait_req(input bit wr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge sys_clk);
      seen = wr ? mem_write_req : mem_read_req;
    end
    check(wr ? "wr_req_seen" : "rd_req_seen", 64'(seen), 64'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_ready"}, 64'(wr_ready), 64'(1));
    check({tag, "_empty"},    64'(empty),    64'(1));
    check({tag, "_full"},     64'(full),     64'(0));
    check({tag, "_count"},    64'(count),    64'(0));
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops_before;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    #1 reset = 1'b1;
    #12;
    check_idle_outputs("reset");
    check("reset_wr_req",  64'(mem_write_req), 64'(0));
    check("reset_rd_req",  64'(mem_read_req),  64'(0));
    check("reset_timeout", 64'(timeout_err),   64'(0));
    check("reset_rd_data", 64'(rd_data),       64'(0));
    @(negedge sys_clk);
    reset = 1'b0;
    cycles(2);

    // Four words in; the first is prefetched into the pop register.
    for (int i = 1; i <= 4; i++) push(32'hA5A5_0000 + 32'(i));
    cycles(60);
    check("t1_count",    64'(count),    64'(3));
    check("t1_rd_valid", 64'(rd_valid), 64'(1));
    check("t1_rd_data",  64'(rd_data),  64'h0000_0000_A5A5_0001);
    check("t1_empty",    64'(empty),    64'(0));
    drain();
    cycles(10);
    check_idle_outputs("t1_end");

    // Fill the 4-word ring: prefetch reg + 4 in RAM + push reg.
    for (int i = 1; i <= 6; i++) push(32'hB0B0_0000 + 32'(i));
    cycles(80);
    check("t2_count",    64'(count),    64'(4));
    check("t2_full",     64'(full),     64'(1));
    check("t2_wr_ready", 64'(wr_ready), 64'(0));
    check("t2_rd_data",  64'(rd_data),  64'h0000_0000_B0B0_0001);
    pop_one();
    cycles(40);
    check("t2_count2",    64'(count),    64'(4));
    check("t2_full2",     64'(full),     64'(1));
    check("t2_wr_ready2", 64'(wr_ready), 64'(1));
    check("t2_rd_data2",  64'(rd_data),  64'h0000_0000_B0B0_0002);
    drain();
    cycles(10);
    check_idle_outputs("t2_end");

    // Continuous streaming with the consumer always ready.
    pops_before = n_pop;
    rd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) push(32'hC000_0000 + 32'(i));
    drain();
    cycles(2);
    check("t3_pops", 64'(n_pop - pops_before), 64'(1000));
    check_idle_outputs("t3_end");

    // Memory never acknowledges: timeout after 15 cycles, then retry.
    never_busy = 1'b1;
    push(32'hDEAD_0001);
    wait_req(1'b1);
    repeat (14) @(negedge sys_clk);
    check("t4_tmo_early", 64'(timeout_err), 64'(0));
    @(negedge sys_clk);
    check("t4_tmo_set",   64'(timeout_err), 64'(1));
    check("t4_count",     64'(count),       64'(0));
    @(negedge sys_clk);
    check("t4_retry_req", 64'(mem_write_req), 64'(1));
    @(posedge sys_clk);
    #1 flush = 1'b1;
    @(posedge sys_clk);
    #1 flush = 1'b0;
    cycles(40);
    check("t4_tmo_clear", 64'(timeout_err), 64'(0));
    check_idle_outputs("t4_flush");
    exp_rd.delete();
    exp_wr.delete();
    never_busy = 1'b0;
    cycles(5);

    // Flush while a read is in RD_DONE: the read finishes, then all clears.
    push(32'hE000_0001);
    push(32'hE000_0002);
    cycles(40);
    check("t5_rd_valid", 64'(rd_valid), 64'(1));
    pop_one();
    wait_req(1'b0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    flush = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0;
    cycles(30);
    check_idle_outputs("t5_flush");
    exp_rd.delete();
    exp_wr.delete();
    push(32'hE000_0003);
    drain();
    cycles(10);
    check_idle_outputs("t5_end");

    // Reset in the middle of a write handshake.
    push(32'hF000_0001);
    wait_req(1'b1);
    reset = 1'b1;
    #1;
    check_idle_outputs("t6_reset");
    check("t6_wr_req",   64'(mem_write_req), 64'(0));
    check("t6_mem_addr", 64'(mem_addr),      64'(0));
    check("t6_mem_data", 64'(mem_data_o),    64'(0));
    exp_rd.delete();
    exp_wr.delete();
    @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b0;
    cycles(2);
    push(32'hF000_0002);
    drain();
    cycles(10);
    check_idle_outputs("t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
